// File: rtl/regfile_sb.sv
// Register file with two async read ports, one sync write port and a per-register pending-write scoreboard.
// Optional write-through forwarding on the read ports is enabled by defining REGFILE_BYPASS_EN.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              wcancel,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic              rbusy1,
    output logic              rbusy2,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_addr,
    output logic              issue_ready,
    output logic [ADDR_W:0]   pend_count
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = ADDR_W + 1;
    localparam bit ZR    = (ZERO_REG != 0);

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  pend_q, pend_d;
    logic [CNT_W-1:0]  pend_count_q, pend_count_d;

    logic wr_en, set_fire, clr_fire;
    logic byp1, byp2;
    logic [DATA_W-1:0] stored1, stored2;

    // Issue handshake: issue_ready depends only on the stored pending bit of issue_addr,
    // never on issue_valid; a reservation is taken on a posedge where both are high.
    assign issue_ready = !pend_q[issue_addr];

    always_comb begin
        wr_en    = we && !wcancel && !(ZR && (waddr == '0));
        set_fire = issue_valid && issue_ready && !(ZR && (issue_addr == '0));
        // A set and a clear on the same index are mutually exclusive: set needs the bit low,
        // a counted clear needs it high.
        clr_fire = we && pend_q[waddr];
    end

    always_comb begin
        regs_d       = regs_q;
        pend_d       = pend_q;
        pend_count_d = pend_count_q;
        if (wr_en)
            regs_d[waddr] = wdata;
        if (we)
            pend_d[waddr] = 1'b0;
        if (set_fire)
            pend_d[issue_addr] = 1'b1;
        case ({set_fire, clr_fire})
            2'b10:   pend_count_d = pend_count_q + CNT_W'(1);
            2'b01:   pend_count_d = pend_count_q - CNT_W'(1);
            default: pend_count_d = pend_count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                regs_q[i] <= '0;
            pend_q       <= '0;
            pend_count_q <= '0;
        end else begin
            regs_q       <= regs_d;
            pend_q       <= pend_d;
            pend_count_q <= pend_count_d;
        end
    end

    always_comb begin
        stored1 = (ZR && (raddr1 == '0)) ? '0 : regs_q[raddr1];
        stored2 = (ZR && (raddr2 == '0)) ? '0 : regs_q[raddr2];
`ifdef REGFILE_BYPASS_EN
        byp1 = wr_en && (waddr == raddr1);
        byp2 = wr_en && (waddr == raddr2);
`else
        byp1 = 1'b0;
        byp2 = 1'b0;
`endif
        rdata1 = byp1 ? wdata : stored1;
        rdata2 = byp2 ? wdata : stored2;
        rbusy1 = byp1 ? 1'b0 : pend_q[raddr1];
        rbusy2 = byp2 ? 1'b0 : pend_q[raddr2];
    end

    assign pend_count = pend_count_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (default parameters, ZERO_REG=1).
module tb_regfile_sb;
    logic        clk = 1'b0;
    logic        rst;
    logic        we, wcancel;
    logic [4:0]  waddr, raddr1, raddr2, issue_addr;
    logic [31:0] wdata;
    logic [31:0] rdata1, rdata2;
    logic        rbusy1, rbusy2;
    logic        issue_valid, issue_ready;
    logic [5:0]  pend_count;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .we(we), .wcancel(wcancel), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
        .rbusy1(rbusy1), .rbusy2(rbusy2), .issue_valid(issue_valid),
        .issue_addr(issue_addr), .issue_ready(issue_ready), .pend_count(pend_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; wcancel = 1'b0; waddr = '0; wdata = '0;
        issue_valid = 1'b0; issue_addr = '0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 10; i++) begin
            we = 1'b1; wcancel = 1'b0;
            waddr = 5'($urandom_range(1, 31)); wdata = $urandom;
            issue_valid = 1'b1; issue_addr = 5'($urandom_range(1, 31));
            tick();
        end
        rst = 1'b1;
        we = 1'b1; waddr = 5'd4; wdata = 32'hFFFF_FFFF;
        issue_valid = 1'b1; issue_addr = 5'd6;
        tick();
        rst = 1'b0;
        idle();
        for (int a = 0; a < 32; a++) begin
            raddr1 = 5'(a); raddr2 = 5'(31 - a); issue_addr = 5'(a);
            #1;
            if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_rdata a=%0d got %h/%h want 0/0", a, rdata1, rdata2);
            end
            n_checks++;
            if (rbusy1 !== 1'b0 || rbusy2 !== 1'b0 || issue_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_busy a=%0d got rbusy=%b%b ready=%b want 00/1", a, rbusy1, rbusy2, issue_ready);
            end
            n_checks++;
        end
        if (pend_count !== 6'd0) begin
            n_fail++; $display("FAIL reset_pend_count got %0d want 0", pend_count);
        end
        n_checks++;
    endtask

    task automatic test_write();
        we = 1'b1; wcancel = 1'b0; waddr = 5'd5; wdata = 32'hDEAD_BEEF;
        tick();
        idle(); raddr1 = 5'd5;
        #1;
        if (rdata1 !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL write_data got %h want deadbeef", rdata1);
        end
        n_checks++;
        we = 1'b1; wcancel = 1'b1; waddr = 5'd5; wdata = 32'h1234_5678;
        tick();
        idle();
        #1;
        if (rdata1 !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL write_cancel got %h want deadbeef", rdata1);
        end
        n_checks++;
    endtask

    task automatic test_zero_reg();
        we = 1'b1; wcancel = 1'b0; waddr = 5'd0; wdata = 32'h1234;
        issue_valid = 1'b1; issue_addr = 5'd0;
        #1;
        if (issue_ready !== 1'b1) begin
            n_fail++; $display("FAIL zero_issue_ready got %b want 1", issue_ready);
        end
        n_checks++;
        tick();
        idle(); raddr1 = 5'd0;
        #1;
        if (rdata1 !== 32'h0 || rbusy1 !== 1'b0 || pend_count !== 6'd0) begin
            n_fail++;
            $display("FAIL zero_reg got rdata=%h rbusy=%b cnt=%0d want 0/0/0", rdata1, rbusy1, pend_count);
        end
        n_checks++;
    endtask

    task automatic test_issue();
        issue_valid = 1'b1; issue_addr = 5'd7;
        tick();
        raddr1 = 5'd7;
        #1;
        if (rbusy1 !== 1'b1 || pend_count !== 6'd1 || issue_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL issue_set got rbusy=%b cnt=%0d ready=%b want 1/1/0", rbusy1, pend_count, issue_ready);
        end
        n_checks++;
        tick();
        if (pend_count !== 6'd1) begin
            n_fail++; $display("FAIL issue_reissue got cnt=%0d want 1", pend_count);
        end
        n_checks++;
        idle();
        we = 1'b1; wcancel = 1'b1; waddr = 5'd7; wdata = 32'hFFFF_0000;
        tick();
        idle(); issue_addr = 5'd7;
        #1;
        if (rbusy1 !== 1'b0 || pend_count !== 6'd0 || rdata1 !== 32'h0 || issue_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL issue_cancel_wb got rbusy=%b cnt=%0d rdata=%h ready=%b want 0/0/0/1",
                     rbusy1, pend_count, rdata1, issue_ready);
        end
        n_checks++;
    endtask

    task automatic test_same_cycle();
        issue_valid = 1'b1; issue_addr = 5'd9;
        tick();
        issue_addr = 5'd3;
        we = 1'b1; wcancel = 1'b0; waddr = 5'd9; wdata = 32'h0000_0099;
        tick();
        idle(); raddr1 = 5'd3; raddr2 = 5'd9;
        #1;
        if (pend_count !== 6'd1 || rbusy1 !== 1'b1 || rbusy2 !== 1'b0 || rdata2 !== 32'h99) begin
            n_fail++;
            $display("FAIL same_cycle_diff got cnt=%0d busy3=%b busy9=%b rdata9=%h want 1/1/0/99",
                     pend_count, rbusy1, rbusy2, rdata2);
        end
        n_checks++;
        issue_valid = 1'b1; issue_addr = 5'd12;
        we = 1'b1; waddr = 5'd12; wdata = 32'h0000_0C0C;
        tick();
        idle(); raddr1 = 5'd12;
        #1;
        if (pend_count !== 6'd2 || rbusy1 !== 1'b1 || rdata1 !== 32'h0C0C) begin
            n_fail++;
            $display("FAIL same_cycle_same got cnt=%0d busy=%b rdata=%h want 2/1/0c0c", pend_count, rbusy1, rdata1);
        end
        n_checks++;
        we = 1'b1; waddr = 5'd20; wdata = 32'h20;
        tick();
        if (pend_count !== 6'd2) begin
            n_fail++; $display("FAIL clear_non_pending got cnt=%0d want 2", pend_count);
        end
        n_checks++;
        waddr = 5'd3; tick();
        waddr = 5'd12; tick();
        idle();
        #1;
        if (pend_count !== 6'd0) begin
            n_fail++; $display("FAIL same_cycle_drain got cnt=%0d want 0", pend_count);
        end
        n_checks++;
    endtask

    task automatic test_fill();
        for (int a = 0; a < 32; a++) begin
            issue_valid = 1'b1; issue_addr = 5'(a);
            tick();
        end
        idle(); issue_addr = 5'd0; raddr1 = 5'd0; raddr2 = 5'd31;
        #1;
        if (pend_count !== 6'd31 || issue_ready !== 1'b1 || rbusy1 !== 1'b0 || rbusy2 !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_full got cnt=%0d ready0=%b busy0=%b busy31=%b want 31/1/0/1",
                     pend_count, issue_ready, rbusy1, rbusy2);
        end
        n_checks++;
        for (int a = 1; a < 32; a++) begin
            we = 1'b1; wcancel = 1'b1; waddr = 5'(a);
            tick();
        end
        idle();
        #1;
        if (pend_count !== 6'd0) begin
            n_fail++; $display("FAIL fill_drain got cnt=%0d want 0", pend_count);
        end
        n_checks++;
    endtask

    task automatic test_bypass();
        issue_valid = 1'b1; issue_addr = 5'd8;
        tick();
        idle(); raddr2 = 5'd8;
        we = 1'b1; wcancel = 1'b1; waddr = 5'd8; wdata = 32'h5555_5555;
        #1;
        if (rdata2 !== 32'h0 || rbusy2 !== 1'b1) begin
            n_fail++; $display("FAIL bypass_cancel got rdata=%h busy=%b want 0/1", rdata2, rbusy2);
        end
        n_checks++;
        wcancel = 1'b0; wdata = 32'hA5A5_0001;
        #1;
`ifdef REGFILE_BYPASS_EN
        if (rdata2 !== 32'hA5A5_0001 || rbusy2 !== 1'b0) begin
            n_fail++; $display("FAIL bypass_same_cycle got rdata=%h busy=%b want a5a50001/0", rdata2, rbusy2);
        end
`else
        if (rdata2 !== 32'h0 || rbusy2 !== 1'b1) begin
            n_fail++; $display("FAIL nobypass_same_cycle got rdata=%h busy=%b want 0/1", rdata2, rbusy2);
        end
`endif
        n_checks++;
        tick();
        idle();
        #1;
        if (rdata2 !== 32'hA5A5_0001 || rbusy2 !== 1'b0 || pend_count !== 6'd0) begin
            n_fail++;
            $display("FAIL bypass_after got rdata=%h busy=%b cnt=%0d want a5a50001/0/0", rdata2, rbusy2, pend_count);
        end
        n_checks++;
    endtask

    initial begin
        rst = 1'b1; raddr1 = '0; raddr2 = '0;
        idle();
        tick();
        tick();
        rst = 1'b0;
        test_reset();
        test_write();
        test_zero_reg();
        test_issue();
        test_same_cycle();
        test_fill();
        test_bypass();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
